// File: rtl/sim_controlpath_param.sv
// Control path for the Boolean-network simulator: sequences async/sync rounds,
// tracks consecutive steady rounds, enforces the round limit and reports status.
module sim_controlpath_param #(
    parameter int ROUND_W       = 10,
    parameter int STEADY_ROUNDS = 2,
    parameter int MAX_ROUNDS    = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic               abort,
    input  logic               is_updated,
    input  logic               round_done,
    input  logic               is_steady_state,
    output logic               en_rng,
    output logic               ld_next_state,
    output logic               clr_updated,
    output logic               ld_updated,
    output logic               ld_last_state,
    output logic               steady_state,
    output logic               busy,
    output logic               done,
    output logic               final_steady,
    output logic [ROUND_W-1:0] round_number
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SIM    = 2'd1,
        S_STEADY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]         SR_M1  = 8'(STEADY_ROUNDS - 1);
    localparam logic [7:0]         SR_TOP = 8'(STEADY_ROUNDS);
    localparam logic [ROUND_W-1:0] LIM_M1 =
        ROUND_W'((MAX_ROUNDS == 0) ? 0 : MAX_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] RN_SAT = '1;
    localparam logic               HAS_LIMIT = (MAX_ROUNDS != 0);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               final_q, final_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ROUND_W-1:0] round_q, round_d;

    logic busy_w;
    logic round_ev;
    logic steady_hit;
    logic limit_hit;

    assign busy_w   = (state_q == S_SIM) || (state_q == S_STEADY);
    assign round_ev = busy_w & (mode_q | round_done);
    // Already in STEADY the counter is saturated, so staying needs only a steady round.
    assign steady_hit = round_ev & is_steady_state &
                        ((state_q == S_STEADY) || (cnt_q >= SR_M1));
    assign limit_hit  = HAS_LIMIT & round_ev & (round_q == LIM_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            final_q <= 1'b0;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            final_q <= final_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        final_d = final_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        if (round_ev) begin
            round_d = (round_q == RN_SAT) ? round_q : round_q + 1'b1;
            if (is_steady_state)
                cnt_d = (cnt_q >= SR_TOP) ? SR_TOP : cnt_q + 8'd1;
            else
                cnt_d = '0;
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SIM;
                    mode_d  = mode;
                    final_d = 1'b0;
                    cnt_d   = '0;
                    round_d = '0;
                end
            end
            S_SIM: begin
                if (limit_hit) begin
                    state_d = S_DONE;
                    final_d = steady_hit;
                end else if (steady_hit) begin
                    state_d = S_STEADY;
                end
            end
            S_STEADY: begin
                if (limit_hit) begin
                    state_d = S_DONE;
                    final_d = steady_hit;
                end else if (round_ev && !is_steady_state) begin
                    state_d = S_SIM;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            final_d = final_q;
            cnt_d   = '0;
            round_d = '0;
        end
    end

    always_comb begin
        en_rng        = 1'b0;
        ld_next_state = 1'b0;
        clr_updated   = 1'b0;
        ld_updated    = 1'b0;
        ld_last_state = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: clr_updated = start;
            S_SIM, S_STEADY: begin
                if (mode_q) begin
                    ld_next_state = 1'b1;
                    ld_last_state = 1'b1;
                end else begin
                    en_rng        = ~round_done;
                    ld_next_state = ~is_updated;
                    ld_updated    = ~is_updated;
                    clr_updated   = ~round_done;
                    ld_last_state = round_done;
                end
            end
            default: ;
        endcase
        if (abort) begin
            en_rng        = 1'b0;
            ld_next_state = 1'b0;
            clr_updated   = 1'b0;
            ld_updated    = 1'b0;
            ld_last_state = 1'b0;
        end
    end

    assign steady_state = (state_q == S_STEADY);
    assign busy         = busy_w;
    assign done         = (state_q == S_DONE);
    assign final_steady = final_q;
    assign round_number = round_q;

endmodule

// File: tb/tb_sim_controlpath_param.sv
// Scoreboard bench for sim_controlpath_param.
// Four parameterisations share one stimulus bus.
module tb_sim_controlpath_param;

  logic clk;
  logic rst, start, mode, abort;
  logic is_updated, round_done, is_steady_state;

  logic er [4];
  logic lns[4];
  logic cu [4];
  logic lu [4];
  logic lls[4];
  logic ss [4];
  logic bs [4];
  logic dn [4];
  logic fs [4];
  logic [9:0] rn [3];
  logic [2:0] rn_d;

  logic [18:0] obs [4];

  typedef struct {
    int          d;
    string       nm;
    logic [18:0] e;
  } item_t;

  item_t q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [4:0] C0   = 5'b00000;
  localparam logic [4:0] CCLR = 5'b00100;
  localparam logic [4:0] CASY = 5'b01111;
  localparam logic [4:0] CRD  = 5'b10000;
  localparam logic [4:0] CSYN = 5'b10010;

  sim_controlpath_param #(
    .ROUND_W(10), .STEADY_ROUNDS(2), .MAX_ROUNDS(1000)
  ) u_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .abort(abort), .is_updated(is_updated),
    .round_done(round_done),
    .is_steady_state(is_steady_state),
    .en_rng(er[0]), .ld_next_state(lns[0]),
    .clr_updated(cu[0]), .ld_updated(lu[0]),
    .ld_last_state(lls[0]), .steady_state(ss[0]),
    .busy(bs[0]), .done(dn[0]), .final_steady(fs[0]),
    .round_number(rn[0])
  );

  sim_controlpath_param #(
    .ROUND_W(10), .STEADY_ROUNDS(2), .MAX_ROUNDS(5)
  ) u_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .abort(abort), .is_updated(is_updated),
    .round_done(round_done),
    .is_steady_state(is_steady_state),
    .en_rng(er[1]), .ld_next_state(lns[1]),
    .clr_updated(cu[1]), .ld_updated(lu[1]),
    .ld_last_state(lls[1]), .steady_state(ss[1]),
    .busy(bs[1]), .done(dn[1]), .final_steady(fs[1]),
    .round_number(rn[1])
  );

  sim_controlpath_param #(
    .ROUND_W(10), .STEADY_ROUNDS(2), .MAX_ROUNDS(4)
  ) u_c (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .abort(abort), .is_updated(is_updated),
    .round_done(round_done),
    .is_steady_state(is_steady_state),
    .en_rng(er[2]), .ld_next_state(lns[2]),
    .clr_updated(cu[2]), .ld_updated(lu[2]),
    .ld_last_state(lls[2]), .steady_state(ss[2]),
    .busy(bs[2]), .done(dn[2]), .final_steady(fs[2]),
    .round_number(rn[2])
  );

  sim_controlpath_param #(
    .ROUND_W(3), .STEADY_ROUNDS(2), .MAX_ROUNDS(0)
  ) u_d (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .abort(abort), .is_updated(is_updated),
    .round_done(round_done),
    .is_steady_state(is_steady_state),
    .en_rng(er[3]), .ld_next_state(lns[3]),
    .clr_updated(cu[3]), .ld_updated(lu[3]),
    .ld_last_state(lls[3]), .steady_state(ss[3]),
    .busy(bs[3]), .done(dn[3]), .final_steady(fs[3]),
    .round_number(rn_d)
  );

  assign obs[0] = {rn[0], fs[0], dn[0], bs[0], ss[0],
                   lls[0], lu[0], cu[0], lns[0], er[0]};
  assign obs[1] = {rn[1], fs[1], dn[1], bs[1], ss[1],
                   lls[1], lu[1], cu[1], lns[1], er[1]};
  assign obs[2] = {rn[2], fs[2], dn[2], bs[2], ss[2],
                   lls[2], lu[2], cu[2], lns[2], er[2]};
  assign obs[3] = {7'd0, rn_d, fs[3], dn[3], bs[3], ss[3],
                   lls[3], lu[3], cu[3], lns[3], er[3]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] ev(
    int r, bit f, bit dd, bit b, bit s, logic [4:0] ctl
  );
    return {10'(r), f, dd, b, s, ctl};
  endfunction

  task automatic chk(int d, string nm, logic [18:0] e);
    item_t it;
    it.d  = d;
    it.nm = nm;
    it.e  = e;
    q.push_back(it);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(bit s);
    round_done      = 1'b1;
    is_updated      = 1'b1;
    is_steady_state = s;
    cyc();
    round_done = 1'b0;
    is_updated = 1'b0;
  endtask

  always @(negedge clk) begin
    item_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      total++;
      if (obs[it.d] !== it.e) begin
        bad++;
        $display("FAIL %s dut%0d got=%h expected=%h",
                 it.nm, it.d, obs[it.d], it.e);
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: sequence did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    is_updated = 1'b0; round_done = 1'b0;
    is_steady_state = 1'b0;
    cyc();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (obs[d] !== ev(0, 0, 0, 0, 0, C0)) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%h",
                 d, obs[d]);
      end
    end
    for (int d = 0; d < 4; d++)
      chk(d, "reset", ev(0, 0, 0, 0, 0, C0));
    cyc();
    rst = 1'b0;

    start = 1'b1; mode = 1'b0;
    chk(0, "t1_start", ev(0, 0, 0, 0, 0, CCLR));
    cyc();
    start = 1'b0;
    chk(0, "t1_sim", ev(0, 0, 0, 1, 0, CASY));
    cyc();
    round_done = 1'b1; is_updated = 1'b1;
    is_steady_state = 1'b0;
    chk(0, "t1_rd_ctl", ev(0, 0, 0, 1, 0, CRD));
    cyc();
    round_done = 1'b0; is_updated = 1'b0;
    chk(0, "t1_rn1", ev(1, 0, 0, 1, 0, CASY));
    cyc();
    rd(1'b1);
    chk(0, "t1_rn2", ev(2, 0, 0, 1, 0, CASY));
    cyc();
    rd(1'b1);
    chk(0, "t1_steady", ev(3, 0, 0, 1, 1, CASY));
    cyc();

    rd(1'b0);
    chk(0, "t2_break", ev(4, 0, 0, 1, 0, CASY));
    cyc();
    rd(1'b1);
    chk(0, "t2_one", ev(5, 0, 0, 1, 0, CASY));
    cyc();
    rd(1'b1);
    chk(0, "t2_two", ev(6, 0, 0, 1, 1, CASY));
    cyc();

    rd(1'b0);
    cyc();
    abort = 1'b1; round_done = 1'b1; is_updated = 1'b1;
    chk(0, "t5_abort_cyc", ev(7, 0, 0, 1, 0, C0));
    cyc();
    abort = 1'b0; round_done = 1'b0; is_updated = 1'b0;
    chk(0, "t5_idle", ev(0, 0, 0, 0, 0, C0));
    cyc();
    round_done = 1'b1;
    chk(0, "t5_idle_rd", ev(0, 0, 0, 0, 0, C0));
    cyc();
    round_done = 1'b0;
    chk(0, "t5_idle_rn", ev(0, 0, 0, 0, 0, C0));
    cyc();

    start = 1'b1; mode = 1'b1;
    cyc();
    start = 1'b0; mode = 1'b0;
    chk(0, "t5_sync0", ev(0, 0, 0, 1, 0, CSYN));
    cyc();
    chk(0, "t5_sync1", ev(1, 0, 0, 1, 0, CSYN));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk(0, "t5_rst", ev(0, 0, 0, 0, 0, C0));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    is_steady_state = 1'b0;
    start = 1'b1; mode = 1'b1;
    chk(1, "t3_start", ev(0, 0, 0, 0, 0, CCLR));
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk(1, "t3_sync", ev(k, 0, 0, 1, 0, CSYN));
      cyc();
    end
    chk(1, "t3_done", ev(5, 0, 1, 0, 0, C0));
    cyc();
    chk(1, "t3_hold", ev(5, 0, 1, 0, 0, C0));
    cyc();
    start = 1'b1; mode = 1'b0;
    chk(1, "t3_restart", ev(5, 0, 1, 0, 0, CCLR));
    cyc();
    start = 1'b0;
    chk(1, "t3_rerun", ev(0, 0, 0, 1, 0, CASY));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    start = 1'b1; mode = 1'b0;
    cyc();
    start = 1'b0;
    rd(1'b0);
    cyc();
    rd(1'b0);
    cyc();
    rd(1'b1);
    chk(2, "t4_r3", ev(3, 0, 0, 1, 0, CASY));
    cyc();
    rd(1'b1);
    chk(2, "t4_done", ev(4, 1, 1, 0, 0, C0));
    cyc();
    chk(2, "t4_hold", ev(4, 1, 1, 0, 0, C0));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk(2, "t4_rst", ev(0, 0, 0, 0, 0, C0));
    cyc();

    start = 1'b1; mode = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      rd(1'b0);
      if (k == 7 || k == 10)
        chk(3, "t6_sat", ev(7, 0, 0, 1, 0, CASY));
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    round_done = 1'b1;
    cyc();
    round_done = 1'b0;
    chk(3, "t6_idle_rd", ev(0, 0, 0, 0, 0, C0));
    cyc();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
